// File: rtl/arbiter_client.sv
// arbiter_client: requester-side agent for the 3-way arbiter.
// It queues job lengths from local logic, requests the shared resource,
// owns it for one beat per cycle and then releases it for one REL cycle.
// It reports done, timeout and abort as single-cycle pulses.
// `use` is a reserved word in SystemVerilog, so the ownership strobe is named in_use.
// Every output is a flop or a decode of flops. gnt and job_valid never reach an output combinationally.
module arbiter_client #(
  parameter int DEPTH      = 4,
  parameter int LEN_W      = 4,
  parameter int WAIT_LIMIT = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         job_valid,
  input  logic [LEN_W-1:0]             job_len,
  output logic                         job_ready,
  output logic                         req,
  input  logic                         gnt,
  output logic                         in_use,
  output logic [LEN_W-1:0]             beat_idx,
  output logic                         done,
  output logic                         timeout,
  output logic                         abort,
  output logic [$clog2(DEPTH+1)-1:0]   pending
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] OWN  = 2'd2;
  localparam logic [1:0] REL  = 2'd3;

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  // FSM state. It is kept as a plain named signal so checkers can bind to it.
  logic [1:0]        state;
  logic [LEN_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt;
  logic [LEN_W-1:0]  cur_len;
  logic              done_r;
  logic              timeout_r;
  logic              abort_r;
  logic              push;
  logic              pop;

  // Handshake contract with local logic:
  //   A job is taken on an edge where job_valid is high and job_ready is high.
  //   job_ready is high whenever fewer than DEPTH jobs are held.
  //   One exception applies while the queue is full. A job offered on the edge
  //   that retires the head is also taken, because that slot frees on the same edge.
  //   Any other job offered while full is dropped.
  // The head is retired on the grant-held edge that completes its final beat.
  always_comb begin
    pop  = (state == OWN) && gnt && (beat_idx == cur_len);
    push = job_valid && ((count < DEPTH_C) || pop);
  end

  // Ownership FSM with the wait counter, the beat counter and the pulse flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      beat_idx  <= '0;
      cur_len   <= '0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      abort_r   <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      abort_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state    <= REQ;
            wait_cnt <= '0;
          end
        end
        REQ: begin
          // A grant on the same edge that reaches the limit wins over the timeout.
          if (gnt) begin
            state    <= OWN;
            cur_len  <= mem[rd_ptr];
            beat_idx <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= REL;
            timeout_r <= 1'b1;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        OWN: begin
          // A lost grant outranks completion, even on the final beat.
          if (!gnt) begin
            state    <= REL;
            abort_r  <= 1'b1;
            beat_idx <= '0;
          end else if (beat_idx == cur_len) begin
            state    <= REL;
            done_r   <= 1'b1;
            beat_idx <= '0;
          end else begin
            beat_idx <= beat_idx + LEN_W'(1);
          end
        end
        REL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Queue pointers and occupancy. A push and a pop on the same edge cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage. No reset is needed because the pointers define which entries are valid.
  // When the queue is full, a write lands in the slot being retired on that edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= job_len;
    end
  end

  assign req       = (state == REQ) || (state == OWN);
  assign in_use    = (state == OWN);
  assign done      = done_r;
  assign timeout   = timeout_r;
  assign abort     = abort_r;
  assign pending   = count;
  assign job_ready = (count < DEPTH_C);

endmodule

// File: tb/tb_arbiter_client.sv
// Directed bench for arbiter_client with default parameters: DEPTH=4, LEN_W=4, WAIT_LIMIT=15.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at the same point.
module tb_arbiter_client;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       job_valid;
  logic [3:0] job_len;
  logic       job_ready;
  logic       req;
  logic       gnt;
  logic       in_use;
  logic [3:0] beat_idx;
  logic       done;
  logic       timeout;
  logic       abort;
  logic [2:0] pending;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  arbiter_client #(
    .DEPTH(4),
    .LEN_W(4),
    .WAIT_LIMIT(15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .job_valid(job_valid),
    .job_len(job_len),
    .job_ready(job_ready),
    .req(req),
    .gnt(gnt),
    .in_use(in_use),
    .beat_idx(beat_idx),
    .done(done),
    .timeout(timeout),
    .abort(abort),
    .pending(pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ownership, then checks the beat sequence, the beat count and the done pulse.
  task automatic run_job(input string tag, input int exp_beats);
    int guard;
    int n;
    guard = 0;
    n = 0;
    while (in_use !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    check({tag, " owns"}, 32'(in_use), 32'd1);
    while (in_use === 1'b1 && n < 20) begin
      check({tag, " idx"}, 32'(beat_idx), n);
      n++;
      tick();
    end
    check({tag, " beats"}, n, exp_beats);
    check({tag, " done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int cnt;
    int guard;
    int lens[4];
    lens = '{1, 3, 0, 2};

    // Reset
    rst_n = 1'b0;
    job_valid = 1'b0;
    job_len = '0;
    gnt = 1'b0;
    #2;
    check("rst req", 32'(req), 0);
    check("rst use", 32'(in_use), 0);
    check("rst pending", 32'(pending), 0);
    check("rst ready", 32'(job_ready), 1);
    check("rst flags", {29'd0, done, timeout, abort}, 0);
    check("rst idx", 32'(beat_idx), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Test 1: one 3-beat job with the grant held high
    job_valid = 1'b1;
    job_len = 4'd2;
    tick();
    job_valid = 1'b0;
    check("t1 pending after push", 32'(pending), 1);
    check("t1 req still low", 32'(req), 0);
    gnt = 1'b1;
    tick();
    check("t1 req rises", 32'(req), 1);
    check("t1 use low in REQ", 32'(in_use), 0);
    run_job("t1", 3);
    check("t1 req low REL", 32'(req), 0);
    check("t1 pending drained", 32'(pending), 0);
    tick();
    check("t1 req low IDLE", 32'(req), 0);
    check("t1 done one pulse", 32'(done), 0);
    tick();
    check("t1 stays idle", 32'(req), 0);

    // Test 2: fill the queue, drop a job offered while full, then push and retire on the same edge
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      job_valid = 1'b1;
      job_len = lens[i][3:0];
      tick();
    end
    check("t2 pending full", 32'(pending), 4);
    check("t2 ready low", 32'(job_ready), 0);
    job_len = 4'd7;
    tick();
    job_valid = 1'b0;
    check("t2 fifth ignored", 32'(pending), 4);
    gnt = 1'b1;
    tick();
    check("t2 own first", 32'(in_use), 1);
    check("t2 idx0", 32'(beat_idx), 0);
    tick();
    check("t2 idx1", 32'(beat_idx), 1);
    job_valid = 1'b1;
    job_len = 4'd5;
    tick();
    job_valid = 1'b0;
    check("t2 first done", 32'(done), 1);
    check("t2 push+pop full", 32'(pending), 4);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd6);
    while (exp_q.size() > 0) begin
      run_job("t2 order", int'(exp_q.pop_front()));
    end
    check("t2 drained", 32'(pending), 0);

    // Test 3: no grant, so the request times out and the head is retried
    gnt = 1'b0;
    tick();
    job_valid = 1'b1;
    job_len = 4'd0;
    tick();
    job_valid = 1'b0;
    check("t3 req low push", 32'(req), 0);
    tick();
    check("t3 req up", 32'(req), 1);
    cnt = 0;
    while (req === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    check("t3 req cycles", cnt, 15);
    check("t3 timeout", 32'(timeout), 1);
    check("t3 pending kept", 32'(pending), 1);
    tick();
    check("t3 req low IDLE", 32'(req), 0);
    check("t3 timeout pulse", 32'(timeout), 0);
    tick();
    check("t3 req reassert", 32'(req), 1);
    gnt = 1'b1;
    run_job("t3 retry", 1);
    check("t3 drained", 32'(pending), 0);

    // Test 4: grant lost during beat 3, then a full retry
    job_valid = 1'b1;
    job_len = 4'd5;
    tick();
    job_valid = 1'b0;
    guard = 0;
    while (in_use !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    check("t4 owns", 32'(in_use), 1);
    for (int i = 0; i < 3; i++) begin
      check("t4 idx", 32'(beat_idx), i);
      tick();
    end
    check("t4 idx3", 32'(beat_idx), 3);
    gnt = 1'b0;
    tick();
    check("t4 abort", 32'(abort), 1);
    check("t4 no done", 32'(done), 0);
    check("t4 use low", 32'(in_use), 0);
    check("t4 req low", 32'(req), 0);
    check("t4 pending kept", 32'(pending), 1);
    gnt = 1'b1;
    tick();
    check("t4 abort pulse", 32'(abort), 0);
    run_job("t4 retry", 6);
    check("t4 drained", 32'(pending), 0);

    // Test 5: the grant arrives on the same edge that reaches the wait limit
    gnt = 1'b0;
    job_valid = 1'b1;
    job_len = 4'd1;
    tick();
    job_valid = 1'b0;
    tick();
    check("t5 req up", 32'(req), 1);
    repeat (14) tick();
    check("t5 still REQ", 32'(req), 1);
    check("t5 no early timeout", 32'(timeout), 0);
    gnt = 1'b1;
    tick();
    check("t5 own at limit", 32'(in_use), 1);
    check("t5 no timeout", 32'(timeout), 0);
    run_job("t5", 2);

    // Test 6: asynchronous reset in the middle of ownership
    tick();
    job_valid = 1'b1;
    job_len = 4'd7;
    tick();
    job_valid = 1'b0;
    guard = 0;
    while (in_use !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    tick();
    tick();
    check("t6 mid job idx", 32'(beat_idx), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 req dropped", 32'(req), 0);
    check("t6 use dropped", 32'(in_use), 0);
    check("t6 pending cleared", 32'(pending), 0);
    check("t6 ready", 32'(job_ready), 1);
    check("t6 idx cleared", 32'(beat_idx), 0);
    check("t6 no done", 32'(done), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6 idle req", 32'(req), 0);
      check("t6 idle done", 32'(done), 0);
      check("t6 idle use", 32'(in_use), 0);
    end
    check("t6 pending", 32'(pending), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arbiter_client.md
Name: arbiter_client

Overview:
- Requester-side agent for the 3-way arbiter; one instance per requester.
- Queues job lengths from local logic and drives `req` toward the arbiter.
- Waits for `gnt`, then holds ownership for the job's beat count, then releases with a mandatory idle cycle so the arbiter can rotate.
- Reports completion, timeout and preemption to local logic.

Parameters:
- DEPTH, 4, job queue entries (2..8).
- LEN_W, 4, width of job length field.
- WAIT_LIMIT, 15, consecutive REQ cycles without grant before timeout (1..255).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  job offered this cycle
- job_len  in  LEN_W  beats minus one (0 = 1 beat)
- job_ready  out  1  queue can accept; high when count < DEPTH
- req  out  1  request to arbiter
- gnt  in  1  grant from arbiter for this requester
- use  out  1  resource owned this cycle (one beat)
- beat_idx  out  LEN_W  index of current beat, 0-based
- done  out  1  one-cycle pulse: head job completed
- timeout  out  1  one-cycle pulse: grant not received within WAIT_LIMIT
- abort  out  1  one-cycle pulse: grant lost mid-job
- pending  out  clog2(DEPTH+1)  jobs in queue, including the active job

Behaviour:
- Reset:
  - Asserting rst_n=0 clears the FSM to IDLE, empties the queue and zeroes counters immediately.
  - While in reset: req=0, use=0, done=0, timeout=0, abort=0, beat_idx=0, pending=0, job_ready=1.
  - Reset mid-job drops req and use without a done pulse.
- All outputs are registered or are pure decodes of registered state (Moore). No combinational path from gnt or job_valid to any output.
- Queue:
  - Circular FIFO of job_len values.
  - Push on an edge where job_valid && job_ready.
  - The head is popped only on the edge entering REL with done. Timeout and abort leave the head in place for retry.
  - A push and a pop on the same edge leave pending unchanged and are legal when the queue is full.
  - job_valid while the queue is full is ignored; no overflow.
- FSM states: IDLE, REQ, OWN, REL.
  - IDLE: req=0. If pending>0, go to REQ on the next edge and clear the wait counter. A job pushed at edge t produces req=1 after edge t+1.
  - REQ: req=1.
    - gnt=1 at an edge: go to OWN, load the beat counter with the head length, set beat_idx=0.
    - Otherwise the wait counter increments. When it would reach WAIT_LIMIT, go to REL with timeout=1.
  - OWN: req=1, use=1, beat_idx increments each edge.
    - Edge where beat_idx == head length and gnt=1: go to REL with done=1 and pop the head.
    - Edge where gnt=0 before the last beat: go to REL with abort=1. use falls after that edge. The beat in which gnt was seen low is not counted as complete.
    - gnt=0 on the final beat's edge is also treated as abort.
  - REL: req=0, use=0. The pulse flag is valid for exactly this cycle. Always go to IDLE on the next edge, which guarantees at least 2 cycles with req low between ownerships.
- Priority of simultaneous events at one edge in OWN: abort (gnt=0) > done.
- Priority in REQ: gnt=1 on the same edge the limit is reached wins; go to OWN, no timeout.
- Wrap-around: FIFO pointers wrap modulo DEPTH. beat_idx never exceeds job_len, so it needs no wrap handling.
- Counters are saturating-free by construction; the wait counter width is clog2(WAIT_LIMIT+1).

Test Plan:
1. Reset, push len=2, gnt held 1 → req rises 1 cycle after push edge; use high 3 cycles with beat_idx 0,1,2; done pulse once; req low for 2 cycles; pending 1→0.
2. Push 4 jobs with DEPTH=4 → job_ready low after the 4th. Offer a 5th → ignored. Complete one job with a simultaneous push → pending stays 4; job order preserved (lens 1,3,0,2 → beats 2,4,1,3).
3. Push len=0, gnt held 0 with WAIT_LIMIT=15 → timeout after 15 REQ cycles. req drops for the REL and IDLE cycles, then reasserts. pending stays 1. Grant then → 1 beat, done.
4. Push len=5, gnt drops after beat_idx=2 → abort pulse, use low next cycle. Retry owns again with beat_idx starting at 0 and runs 6 beats, then done.
5. gnt rises on the same edge the wait counter hits the limit → OWN, no timeout pulse.
6. rst_n low mid-OWN for 1 ns asynchronously → req and use low immediately, pending=0, no done. After release, idle until a new push.
